// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: word/byte-enable widths, FSM states,
// the latched request record and the byte-address to word-index helper.
package dmem_pkg;
  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {IDLE, WAIT, COMMIT, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [31:0]       addr;
    logic [WORD_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } req_t;

  // Word index of a byte address, wrapped to an array of 2**aw words.
  function automatic logic [31:0] idx_of(input logic [31:0] addr, input int unsigned aw);
    logic [31:0] mask;
    mask = (32'd1 << aw) - 32'd1;
    return (addr >> 2) & mask;
  endfunction
endpackage

// File: rtl/dmem_array.sv
// Purpose: DEPTH x 32 single-port storage, byte-enabled synchronous write, synchronous read.
// Latency: read data registered one cycle after en with we=0; rdata holds until the next read.
// Backpressure: none; the caller enables it for exactly one cycle per access.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [BE_W-1:0]          be,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [WORD_W-1:0]        wdata,
  output logic [WORD_W-1:0]        rdata
);
  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// Purpose: data-memory responder, one transaction in flight, LATENCY programmable wait states (DMEM_ERR_CHECK_EN adds error checks).
// Latency: resp_valid rises LATENCY+2 cycles after the cycle the request handshake is seen.
// Backpressure: response held stable in RESP until resp_ready; req_ready low outside IDLE.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);
  localparam int AW = $clog2(DEPTH);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  req_t              req_q;
  logic              rd_zero_q;
  logic              resp_err_q;
  logic              err;
  logic              arr_en;
  logic [AW-1:0]     idx;
  logic [WORD_W-1:0] arr_rdata;

  assign idx = AW'(idx_of(req_q.addr, AW));

`ifdef DMEM_ERR_CHECK_EN
  assign err = (req_q.addr[1:0] != 2'b00) || ((req_q.addr >> (AW + 2)) != 32'd0);
`else
  assign err = 1'b0;
`endif

  assign req_ready  = rst && (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_err   = resp_err_q;
  // Array read register only moves on a load commit, so it doubles as the held response data.
  assign resp_rdata = rd_zero_q ? '0 : arr_rdata;
  assign arr_en     = rst && (state == COMMIT) && !err;

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (req_q.we),
    .be    (req_q.be),
    .idx   (idx),
    .wdata (req_q.wdata),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_nxt = COMMIT;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = COMMIT;
        else             cnt_nxt   = cnt - 4'd1;
      end
      COMMIT: state_nxt = RESP;
      RESP:   if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rd_zero_q  <= 1'b1;
      resp_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req_valid) begin
        req_q <= '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
      end
      if (state == COMMIT) begin
        rd_zero_q  <= req_q.we || err;
        resp_err_q <= err;
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;
  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_m [DEPTH];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          last_acc;
  bit          in_resp = 0;
  bit          hold_bp = 0;
  bit          rr_full = 0;
  logic [31:0] held_rdata;
  logic        held_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: index wraps modulo DEPTH; optional error rule; stores merge enabled bytes.
  function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, output logic [31:0] rd, output logic er);
    int unsigned idx;
    idx = (addr / 4) % DEPTH;
    er  = 1'b0;
`ifdef DMEM_ERR_CHECK_EN
    er = (addr % 4 != 0) || (addr >= 4 * DEPTH);
`endif
    rd = 32'h0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < 4; i++) if (be[i]) mem_m[idx][8*i +: 8] = wdata[8*i +: 8];
      end else begin
        rd = mem_m[idx];
      end
    end
  endfunction

  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    int   guard;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    guard = 0;
    while (!req_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      check("req_accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    last_acc = cyc;
    model(we, addr, wdata, be, e.rdata, e.err);
    e.acc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = $urandom; req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sb.size() != 0 || in_resp) && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() != 0 || in_resp) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      resp_ready = hold_bp ? 1'b0 : (rr_full ? 1'b1 : ($urandom_range(0, 3) != 0));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      in_resp = 0;
    end else if (resp_valid) begin
      if (!in_resp) begin
        in_resp    = 1;
        held_rdata = resp_rdata;
        held_err   = resp_err;
        if (sb.size() == 0) check("unexpected_resp", 32'd1, 32'd0);
        else check("first_resp_latency", 32'(cyc - sb[0].acc), 32'(LATENCY + 2));
      end else begin
        check("rdata_stable", resp_rdata, held_rdata);
        check("err_stable", 32'(resp_err), 32'(held_err));
      end
      check("req_ready_low_in_resp", 32'(req_ready), 32'd0);
      if (resp_ready) begin
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", 32'(resp_err), 32'(e.err));
        end
        in_resp = 0;
      end
    end
  end

  initial begin
    int g;
    int prev;
    logic [31:0] a;
    rst = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30;
    req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;

    repeat (3) begin
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
    end
    rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    check("req_ready_after_rst", 32'(req_ready), 32'd1);

    for (int i = 0; i < DEPTH; i++) xact(1'b1, 32'(i * 4), $urandom, 4'hF);
    drain();

    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    xact(1'b0, 32'h10, 32'h0, 4'h0);
    xact(1'b1, 32'h20, 32'h11223344, 4'hF);
    xact(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
    xact(1'b1, 32'h24, 32'hCAFEF00D, 4'b0000);
    xact(1'b0, 32'h24, 32'h0, 4'h0);
    drain();

    hold_bp = 1;
    xact(1'b0, 32'h20, 32'h0, 4'h0);
    g = 0;
    while (!resp_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    repeat (5) @(negedge clk);
    check("bp_resp_valid_held", 32'(resp_valid), 32'd1);
    check("bp_rdata_held", resp_rdata, 32'h11BB33DD);
    hold_bp = 0;
    drain();
    @(negedge clk);
    check("bp_back_to_idle", 32'(req_ready), 32'd1);

    xact(1'b1, 32'h30, 32'h0, 4'hF);
    drain();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h55555555; req_be = 4'hF;
    g = 0;
    while (!req_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("midwait_rst_resp_valid", 32'(resp_valid), 32'd0);
    check("midwait_rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    xact(1'b0, 32'h30, 32'h0, 4'h0);
    drain();

    xact(1'b0, 32'h402, 32'h0, 4'h0);
    xact(1'b0, 32'h3FC, 32'h0, 4'h0);
    xact(1'b1, 32'h401, 32'h12345678, 4'hF);
    xact(1'b0, 32'h0, 32'h0, 4'h0);
    drain();

    rr_full = 1;
    @(negedge clk);
    prev = -1;
    for (int k = 0; k < 6; k++) begin
      xact(1'b0, 32'(k * 4), 32'h0, 4'h0);
      if (prev >= 0) check("throughput", 32'(last_acc - prev), 32'(LATENCY + 3));
      prev = last_acc;
    end
    drain();
    rr_full = 0;

    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 6))
        0:       a = $urandom;
        1:       a = {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
        default: a = {22'd0, 8'($urandom), 2'b00};
      endcase
      xact(1'($urandom), a, $urandom, 4'($urandom));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
